// File: rtl/control_unit_if.sv
// Control bus between the multicycle control FSM and its datapath.
// The controller (master) reads the opcode and drives every strobe/select.
interface control_unit_if;
   logic [5:0] OP;
   logic       BEQ_BNE;
   logic [1:0] PCSource;
   logic [2:0] ALUOp;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       RegWrite;
   logic       IRWrite;
   logic       MemToReg;
   logic       MemToWrite;
   logic       MemToRead;
   logic       IorD;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       Illegal;
   logic [3:0] State;

   modport master (
      input  OP,
      output BEQ_BNE, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, IRWrite,
             MemToReg, MemToWrite, MemToRead, IorD, PCWrite, PCWriteCond,
             Illegal, State
   );

   modport slave (
      output OP,
      input  BEQ_BNE, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, IRWrite,
             MemToReg, MemToWrite, MemToRead, IorD, PCWrite, PCWriteCond,
             Illegal, State
   );
endinterface

// File: rtl/control_unit.sv
// Multicycle Moore control FSM: FETCH/DECODE followed by a short
// per-class execution path, returning to FETCH. Outputs are decoded from
// the current state; only ALUOp (EXEC_I) and BEQ_BNE (DECODE/BRANCH)
// look at the opcode, plus the one-cycle Illegal flag in DECODE.
module control_unit #(
   parameter logic [2:0] ALU_ADD = 3'b010,
   parameter logic [2:0] ALU_SUB = 3'b110
) (
   input  logic          clk,
   input  logic          rst,
   control_unit_if.master bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_I   = 4'd2,
      WB_ALU   = 4'd3,
      LI_EXEC  = 4'd4,
      LI_WB    = 4'd5,
      MEM_ADDR = 4'd6,
      MEM_RD   = 4'd7,
      MEM_WB   = 4'd8,
      MEM_WR   = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   state_t r_state;
   logic   w_alu, w_li, w_mem, w_br, w_jmp;

   // Opcode class decode; anything not matched is illegal
   always_comb begin
      w_alu = 1'b0;
      w_li  = 1'b0;
      w_mem = 1'b0;
      w_br  = 1'b0;
      w_jmp = 1'b0;
      casez (bus.OP)
         6'b000???:         w_alu = 1'b1;
         6'b010000:         w_li  = 1'b1;
         6'b010001,
         6'b010010:         w_mem = 1'b1;
         6'b10000?:         w_br  = 1'b1;
         6'b110000:         w_jmp = 1'b1;
         default:           ;
      endcase
   end

   // State register; reset jumps straight to FETCH regardless of clk
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= FETCH;
      end else begin
         case (r_state)
            FETCH:    r_state <= DECODE;
            DECODE: begin
               if      (w_alu) r_state <= EXEC_I;
               else if (w_li)  r_state <= LI_EXEC;
               else if (w_mem) r_state <= MEM_ADDR;
               else if (w_br)  r_state <= BRANCH;
               else if (w_jmp) r_state <= JUMP;
               else            r_state <= FETCH;
            end
            EXEC_I:   r_state <= WB_ALU;
            LI_EXEC:  r_state <= LI_WB;
            MEM_ADDR: r_state <= (bus.OP[1:0] == 2'b01) ? MEM_RD : MEM_WR;
            MEM_RD:   r_state <= MEM_WB;
            default:  r_state <= FETCH;   // single-step paths and unused codes
         endcase
      end
   end

   // Output decode; reset forces everything low, including the FETCH strobes
   always_comb begin
      bus.BEQ_BNE     = 1'b0;
      bus.PCSource    = 2'b00;
      bus.ALUOp       = 3'b000;
      bus.ALUSrcA     = 1'b0;
      bus.ALUSrcB     = 2'b00;
      bus.RegWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.MemToReg    = 1'b0;
      bus.MemToWrite  = 1'b0;
      bus.MemToRead   = 1'b0;
      bus.IorD        = 1'b0;
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.Illegal     = 1'b0;
      bus.State       = r_state;
      if (rst) begin
         case (r_state)
            FETCH: begin
               bus.MemToRead = 1'b1;
               bus.IRWrite   = 1'b1;
               bus.PCWrite   = 1'b1;
               bus.ALUSrcB   = 2'b01;
               bus.ALUOp     = ALU_ADD;
            end
            DECODE: begin
               bus.ALUSrcB = 2'b11;
               bus.ALUOp   = ALU_ADD;
               bus.BEQ_BNE = bus.OP[0];
               bus.Illegal = ~(w_alu | w_li | w_mem | w_br | w_jmp);
            end
            EXEC_I: begin
               bus.ALUSrcA = 1'b1;
               bus.ALUOp   = bus.OP[2:0];
            end
            WB_ALU:   bus.RegWrite = 1'b1;
            LI_EXEC, LI_WB: begin
               bus.ALUSrcA  = 1'b1;
               bus.ALUSrcB  = 2'b11;
               bus.ALUOp    = ALU_ADD;
               bus.RegWrite = (r_state == LI_WB);
            end
            MEM_ADDR: begin
               bus.ALUSrcA = 1'b1;
               bus.ALUSrcB = 2'b10;
               bus.ALUOp   = ALU_ADD;
            end
            MEM_RD: begin
               bus.IorD      = 1'b1;
               bus.MemToRead = 1'b1;
            end
            MEM_WB: begin
               bus.RegWrite = 1'b1;
               bus.MemToReg = 1'b1;
            end
            MEM_WR: begin
               bus.IorD       = 1'b1;
               bus.MemToWrite = 1'b1;
            end
            BRANCH: begin
               bus.ALUSrcA     = 1'b1;
               bus.ALUOp       = ALU_SUB;
               bus.PCWriteCond = 1'b1;
               bus.PCSource    = 2'b01;
               bus.BEQ_BNE     = bus.OP[0];
            end
            JUMP: begin
               bus.PCSource = 2'b10;
               bus.PCWrite  = 1'b1;
            end
            default: bus.State = r_state;  // unused codes: all strobes stay 0
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the stimulus process walks a
// reference instruction model, pushing the expected output vector for each
// cycle; a negedge monitor pops and compares, and also checks the
// strobe-exclusivity rules every cycle.
module tb_control_unit;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   control_unit_if bus ();

   control_unit #(.ALU_ADD(3'b010), .ALU_SUB(3'b110)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   typedef struct {
      logic [21:0] v;
      string       name;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_on = 1'b0;

   // {State, BEQ_BNE, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, IRWrite,
   //  MemToReg, MemToWrite, MemToRead, IorD, PCWrite, PCWriteCond, Illegal}
   function automatic logic [21:0] act();
      return {bus.State, bus.BEQ_BNE, bus.PCSource, bus.ALUOp, bus.ALUSrcA,
              bus.ALUSrcB, bus.RegWrite, bus.IRWrite, bus.MemToReg,
              bus.MemToWrite, bus.MemToRead, bus.IorD, bus.PCWrite,
              bus.PCWriteCond, bus.Illegal};
   endfunction

   task automatic chk(input string name, input logic [21:0] a, input logic [21:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, a, e);
      end
   endtask

   // Reference: opcode class by the opcode table
   function automatic int op_class(input logic [5:0] op);
      if (op[5:3] == 3'b000)      return 0;  // ALU immediate
      if (op == 6'b010000)        return 1;  // LI
      if (op == 6'b010001)        return 2;  // LW
      if (op == 6'b010010)        return 3;  // SW
      if (op[5:1] == 5'b10000)    return 4;  // BEQ/BNE
      if (op == 6'b110000)        return 5;  // JUMP
      return 6;                              // illegal
   endfunction

   // Reference: state codes visited by each class, FETCH first
   function automatic void seq_of(input logic [5:0] op, output int s[$]);
      case (op_class(op))
         0: s = '{0, 1, 2, 3};
         1: s = '{0, 1, 4, 5};
         2: s = '{0, 1, 6, 7, 8};
         3: s = '{0, 1, 6, 9};
         4: s = '{0, 1, 10};
         5: s = '{0, 1, 11};
         default: s = '{0, 1};
      endcase
   endfunction

   // Reference: per-state output listing, unlisted outputs are 0
   function automatic logic [21:0] expv(input int st, input logic [5:0] op);
      logic       beq = 0, srca = 0, rw = 0, irw = 0, m2r = 0, mw = 0, mr = 0;
      logic       iord = 0, pcw = 0, pcc = 0, ill = 0;
      logic [1:0] pcs = 0, srcb = 0;
      logic [2:0] aop = 0;
      case (st)
         0:  begin mr = 1; irw = 1; pcw = 1; srcb = 2'b01; aop = 3'b010; end
         1:  begin srcb = 2'b11; aop = 3'b010; beq = op[0]; ill = (op_class(op) == 6); end
         2:  begin srca = 1; aop = op[2:0]; end
         3:  rw = 1;
         4:  begin srca = 1; srcb = 2'b11; aop = 3'b010; end
         5:  begin srca = 1; srcb = 2'b11; aop = 3'b010; rw = 1; end
         6:  begin srca = 1; srcb = 2'b10; aop = 3'b010; end
         7:  begin iord = 1; mr = 1; end
         8:  begin rw = 1; m2r = 1; end
         9:  begin iord = 1; mw = 1; end
         10: begin srca = 1; aop = 3'b110; pcc = 1; pcs = 2'b01; beq = op[0]; end
         11: begin pcs = 2'b10; pcw = 1; end
         default: ;
      endcase
      return {4'(st), beq, pcs, aop, srca, srcb, rw, irw, m2r, mw, mr, iord,
              pcw, pcc, ill};
   endfunction

   // States where the opcode is no longer consulted; OP is scrambled there
   function automatic bit op_free(input int st);
      return st inside {3, 4, 5, 7, 8, 9, 11};
   endfunction

   // Called at posedge+1 while the DUT sits in FETCH; returns at posedge+1
   // of the next FETCH. abort_at >= 0 pulls reset in the middle of that step.
   task automatic run_instr(input logic [5:0] op, input int abort_at);
      int s[$];
      seq_of(op, s);
      for (int i = 0; i < s.size(); i++) begin
         if (i == 0)              bus.OP = op;
         else if (op_free(s[i]))  bus.OP = 6'($urandom);
         q.push_back('{expv(s[i], bus.OP), $sformatf("op%b_st%0d", op, s[i])});
         if (i == abort_at) begin
            @(negedge clk); #2;
            rst = 1'b0;
            #1 chk("async_reset", act(), 22'd0);
            @(posedge clk); #1;
            chk("held_reset", act(), 22'd0);
            rst = 1'b1;
            return;
         end
         @(posedge clk); #1;
      end
   endtask

   // Monitor: pop and compare each cycle, plus exclusivity rules
   always @(negedge clk) begin
      exp_t e;
      if (mon_on) begin
         if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, act(), e.v);
         end
         checks++;
         if (!$onehot0({bus.MemToRead, bus.MemToWrite, bus.RegWrite}) ||
             (bus.PCWrite && bus.PCWriteCond)) begin
            errors++;
            $display("FAIL strobe_excl: rd=%b wr=%b rw=%b pcw=%b pcc=%b",
                     bus.MemToRead, bus.MemToWrite, bus.RegWrite,
                     bus.PCWrite, bus.PCWriteCond);
         end
      end
   end

   initial begin
      logic [5:0] op;
      int         s[$];
      bus.OP = 6'b000000;
      // Reset state: everything low, FETCH code
      repeat (3) begin
         @(negedge clk);
         chk("reset_state", act(), 22'd0);
      end
      @(posedge clk); #1;
      rst    = 1'b1;
      mon_on = 1'b1;

      // Directed: jump, ALU imm, LW, SW, BNE, illegal, LW aborted in MEM_RD
      run_instr(6'b110000, -1);
      run_instr(6'b000110, -1);
      run_instr(6'b010001, -1);
      run_instr(6'b010010, -1);
      run_instr(6'b100001, -1);
      run_instr(6'b111111, -1);
      run_instr(6'b010001, 3);
      run_instr(6'b100000, -1);
      run_instr(6'b010000, -1);

      // Random instruction stream with occasional mid-instruction resets
      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 7))
            0: op = {3'b000, 3'($urandom)};
            1: op = 6'b010000;
            2: op = 6'b010001;
            3: op = 6'b010010;
            4: op = {5'b10000, 1'($urandom)};
            5: op = 6'b110000;
            default: begin
               op = 6'($urandom);
               while (op_class(op) != 6) op = 6'($urandom);
            end
         endcase
         seq_of(op, s);
         if ($urandom_range(0, 15) == 0)
            run_instr(op, $urandom_range(1, s.size() - 1));
         else
            run_instr(op, -1);
      end

      @(negedge clk); #1;
      mon_on = 1'b0;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
